// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
// Frame states, SPI mode encodings ({cpol,cpha}) and default parameter values.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    TRANSFER = 2'd2,
    CS_HOLD  = 2'd3
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CS_COUNT   = 4;
  localparam int DEF_DIV_WIDTH  = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator for spi_master_param.
// Counts half-periods of (div+1) clk cycles while enabled and, while toggling
// is enabled, flips sck at each half-period end. lead_edge/trail_edge are
// asserted in the cycle whose closing clk edge produces that sck transition.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 toggle_en,
  input  logic                 idle_level,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 half_end,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sck
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 phase;

  assign half_end   = en && (cnt == div);
  assign lead_edge  = toggle_en && half_end && !phase;
  assign trail_edge = toggle_en && half_end && phase;

  // Half-period counter: wraps at div, parked at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (!en || half_end) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // Edge parity: low means the next sck transition is a leading edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           phase <= 1'b0;
    else if (!toggle_en) phase <= 1'b0;
    else if (half_end)  phase <= !phase;
  end

  // SCK follows the idle level when disabled and holds it through setup/hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        sck <= 1'b0;
    else if (!en)                    sck <= idle_level;
    else if (toggle_en && half_end)  sck <= !sck;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with runtime CPOL/CPHA, programmable SCK divider and
// automatic chip-select framing (one half-period setup and hold).
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input selecting
// LSB-first shifting for both directions; without it frames are MSB first.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CS_COUNT   = DEF_CS_COUNT,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int CS_SEL_W   = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [CS_SEL_W-1:0]   cs_sel,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic [CS_COUNT-1:0]   cs_n,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  new_data
`ifdef SPI_LSB_FIRST_EN
  ,
  input  logic                  lsb_first
`endif
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  spi_state_t            state, state_nx;
  logic [DATA_WIDTH-1:0] tx_q, rx_q;
  logic                  cpha_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [CS_SEL_W-1:0]   cs_sel_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  lsb_mode;
  logic                  half_end, lead_edge, trail_edge, toggle_en;
  logic                  accept, last_bit, shift_tx, sample_rx;

  assign accept    = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign toggle_en = (state == TRANSFER);
  assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  // CPHA=1 keeps the MSB on the first leading edge; CPHA=0 never shifts after the final edge.
  assign shift_tx  = cpha_q ? (lead_edge && (bit_cnt != '0)) : (trail_edge && !last_bit);
  assign sample_rx = cpha_q ? trail_edge : lead_edge;
  assign mosi      = lsb_mode ? tx_q[0] : tx_q[DATA_WIDTH-1];

  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (busy),
    .toggle_en  (toggle_en),
    .idle_level (cpol),
    .div        (div_q),
    .half_end   (half_end),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sck        (sck)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and chip-select decode (out-of-range cs_sel asserts none).
  always_comb begin
    state_nx = state;
    cs_n     = '1;
    case (state)
      IDLE:     if (start)                  state_nx = CS_SETUP;
      CS_SETUP: if (half_end)               state_nx = TRANSFER;
      TRANSFER: if (trail_edge && last_bit) state_nx = CS_HOLD;
      CS_HOLD:  if (half_end)               state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
    for (int i = 0; i < CS_COUNT; i++) begin
      if (busy && (cs_sel_q == CS_SEL_W'(i))) cs_n[i] = 1'b0;
    end
  end

  // Shadow configuration captured on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpha_q   <= 1'b0;
      div_q    <= '0;
      cs_sel_q <= '0;
    end else if (accept) begin
      cpha_q   <= cpha;
      div_q    <= clk_div;
      cs_sel_q <= cs_sel;
    end
  end

`ifdef SPI_LSB_FIRST_EN
  // Bit-order shadow, captured with the rest of the frame setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lsb_mode <= 1'b0;
    else if (accept) lsb_mode <= lsb_first;
  end
`else
  assign lsb_mode = 1'b0;
`endif

  // TX/RX shift registers and trailing-edge bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q    <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
    end else begin
      if (accept) begin
        tx_q    <= data_in;
        bit_cnt <= '0;
      end
      if (shift_tx)  tx_q <= lsb_mode ? (tx_q >> 1) : (tx_q << 1);
      if (sample_rx) rx_q <= lsb_mode ? {miso, rx_q[DATA_WIDTH-1:1]}
                                      : {rx_q[DATA_WIDTH-2:0], miso};
      if (trail_edge) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  // Received frame publication at the end of CS hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= 1'b0;
      if ((state == CS_HOLD) && half_end) begin
        data_out <= rx_q;
        new_data <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Testbench for spi_master_param: directed scenarios plus randomized frames,
// checked against a bit-level slave model and frame-level expectations.
// Second instance uses CS_COUNT=3 so cs_sel=3 is out of range.
module tb_spi_master_param;
  import spi_pkg::*;

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_AVAIL = 1'b1;
`else
  localparam bit LSB_AVAIL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] clk_div = '0;
  logic [1:0] cs_sel = '0;
  logic       lsb_first = 1'b0;
  logic       loopback = 1'b0;
  logic       slv_miso = 1'b0;
  logic       miso;
  logic       mosi, sck, busy, new_data;
  logic [3:0] cs_n;
  logic [7:0] data_out;
  logic       mosi3, sck3, busy3, new_data3;
  logic [2:0] cs_n3;
  logic [7:0] data_out3;

  int n_chk = 0;
  int n_fail = 0;

  assign miso = loopback ? mosi : slv_miso;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_WIDTH(8), .CS_COUNT(4), .DIV_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .cs_sel(cs_sel), .miso(miso), .mosi(mosi), .sck(sck), .cs_n(cs_n),
    .data_out(data_out), .busy(busy), .new_data(new_data)
`ifdef SPI_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  spi_master_param #(.DATA_WIDTH(8), .CS_COUNT(3), .DIV_WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .cs_sel(cs_sel), .miso(miso), .mosi(mosi3), .sck(sck3), .cs_n(cs_n3),
    .data_out(data_out3), .busy(busy3), .new_data(new_data3)
`ifdef SPI_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete frame with a slave model; mid=1 disturbs inputs during the frame.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] resp, input logic [1:0] mode,
                           input logic [7:0] div, input logic [1:0] sel, input bit loop,
                           input bit lsb, input bit mid);
    logic [7:0] seq_out, got_seq, got_word, exp_rx;
    logic [3:0] exp_cs;
    logic [2:0] exp_cs3;
    logic       prev_sck, prev_mosi;
    int         busy_cyc, rises, edges, nd, k_in, k_out, budget, cyc;
    bit         cs_ok, cs3_ok, stab_ok, mirror_ok, done, lead, samp;
    for (int k = 0; k < 8; k++) seq_out[k] = lsb ? resp[k] : resp[7-k];
    exp_rx  = loop ? tx : resp;
    exp_cs  = 4'hF; exp_cs[sel] = 1'b0;
    exp_cs3 = 3'h7; if (sel < 2'd3) exp_cs3[sel] = 1'b0;
    busy_cyc = 0; rises = 0; edges = 0; nd = 0; k_in = 0; k_out = 0; cyc = 0;
    cs_ok = 1; cs3_ok = 1; stab_ok = 1; mirror_ok = 1; done = 0;
    got_seq = '0;
    @(posedge clk); #1;
    cpol = mode[1]; cpha = mode[0]; clk_div = div; cs_sel = sel; data_in = tx;
    lsb_first = lsb; loopback = loop; slv_miso = seq_out[0];
    @(posedge clk); #1;
    chk("sck_idle", sck, mode[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_sck = sck; prev_mosi = mosi;
    budget = 18 * (int'(div) + 1) + 20;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      if (busy) begin
        busy_cyc++;
        if (cs_n !== exp_cs) cs_ok = 0;
        if (cs_n3 !== exp_cs3) cs3_ok = 0;
      end
      if (busy3 !== busy || sck3 !== sck || mosi3 !== mosi) mirror_ok = 0;
      if (sck !== prev_sck) begin
        edges++;
        if (sck) rises++;
        lead = (edges % 2) == 1;
        samp = mode[0] ? !lead : lead;
        if (samp) begin
          if (mosi !== prev_mosi) stab_ok = 0;
          if (k_out < 8) got_seq[k_out] = mosi;
          k_out++;
        end
        if (!mode[0] && !lead && k_in < 7) begin k_in++; slv_miso = seq_out[k_in]; end
        if (mode[0] && lead && edges <= 15) slv_miso = seq_out[(edges-1)/2];
      end
      prev_sck = sck; prev_mosi = mosi;
      if (mid && cyc == 3) begin
        start = 1'b1; data_in = ~tx; cs_sel = sel + 2'd1; cpha = ~mode[0]; clk_div = div + 8'd1;
      end
      if (mid && cyc == 4) start = 1'b0;
      if (new_data) begin
        nd++; done = 1;
        chk("data_out", data_out, exp_rx);
        chk("data_out3", data_out3, exp_rx);
        chk("new_data3", new_data3, 1);
        chk("busy_low", busy, 0);
        chk("cs_release", cs_n, 4'hF);
        chk("sck_end", sck, mode[1]);
      end
    end
    if (!done) chk("frame_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (new_data) nd++;
    end
    for (int k = 0; k < 8; k++) got_word[lsb ? k : 7-k] = got_seq[k];
    chk("busy_len", busy_cyc, 18 * (int'(div) + 1));
    chk("sck_edges", edges, 16);
    chk("sck_rises", rises, 8);
    chk("mosi_word", got_word, tx);
    chk("mosi_first", got_seq[0], lsb ? tx[0] : tx[7]);
    chk("mosi_stable", stab_ok, 1);
    chk("cs_pattern", cs_ok, 1);
    chk("cs3_pattern", cs3_ok, 1);
    chk("mirror", mirror_ok, 1);
    chk("nd_pulses", nd, 1);
  endtask

  // Asynchronous reset in the middle of a frame.
  task automatic rst_abort();
    int rises, cyc, nd;
    logic prev_sck;
    @(posedge clk); #1;
    cpol = 0; cpha = 0; clk_div = 8'd1; cs_sel = 2'd0; data_in = 8'hC3; loopback = 1; lsb_first = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_sck = sck; rises = 0; cyc = 0;
    while (rises < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
    end
    chk("abort_reached", rises, 4);
    chk("abort_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 4'hF);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_new_data", new_data, 0);
    chk("abort_data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (new_data || busy) nd++;
    end
    chk("abort_no_activity", nd, 0);
  endtask

  // Start held high across two frames through the loopback.
  task automatic back_to_back();
    logic [7:0] outs [2];
    int nd, gap, cyc;
    bit gap_cs_ok;
    @(posedge clk); #1;
    cpol = 0; cpha = 0; clk_div = 8'd0; cs_sel = 2'd2; data_in = 8'h11; loopback = 1; lsb_first = 0;
    @(posedge clk); #1;
    start = 1'b1;
    nd = 0; gap = 0; cyc = 0; gap_cs_ok = 1;
    outs[0] = '0; outs[1] = '0;
    while (nd < 2 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (busy && data_in == 8'h11) data_in = 8'h22;
      if (new_data) begin outs[nd] = data_out; nd++; end
      if (nd == 1) begin
        if (!busy) begin
          gap++;
          if (cs_n !== 4'hF) gap_cs_ok = 0;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_frames", nd, 2);
    chk("b2b_first", outs[0], 8'h11);
    chk("b2b_second", outs[1], 8'h22);
    chk("b2b_gap", gap, 1);
    chk("b2b_gap_cs", gap_cs_ok, 1);
    repeat (3) @(negedge clk);
    chk("b2b_stop", busy, 0);
  endtask

  initial begin
    logic [7:0] tx, resp, div;
    logic [1:0] mode, sel;
    bit loop, lsb;
    repeat (2) @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_new_data", new_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    rst_abort();
    run_frame(8'hA5, 8'h00, SPI_MODE0, 8'd0, 2'd1, 1, 0, 0);
    run_frame(8'h5B, 8'h3C, SPI_MODE1, 8'd3, 2'd0, 0, 0, 0);
    run_frame(8'hE7, 8'h3C, SPI_MODE2, 8'd3, 2'd2, 0, 0, 0);
    run_frame(8'h18, 8'h3C, SPI_MODE3, 8'd3, 2'd3, 0, 0, 0);
    run_frame(8'h5A, 8'h00, SPI_MODE0, 8'd1, 2'd2, 1, 0, 1);
    run_frame(8'h69, 8'hC4, SPI_MODE1, 8'd2, 2'd1, 0, 0, 1);
    back_to_back();
    run_frame(8'h96, 8'h00, SPI_MODE2, 8'd0, 2'd3, 1, 0, 0);
    run_frame(8'h81, 8'h7E, SPI_MODE3, 8'd255, 2'd0, 0, 0, 0);
    if (LSB_AVAIL) begin
      run_frame(8'h01, 8'h00, SPI_MODE0, 8'd0, 2'd1, 1, 1, 0);
      run_frame(8'hB2, 8'h4D, SPI_MODE3, 8'd1, 2'd3, 0, 1, 0);
    end
    for (int n = 0; n < 12; n++) begin
      tx   = 8'($urandom);
      resp = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      div  = 8'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      loop = 1'($urandom_range(0, 1));
      lsb  = LSB_AVAIL ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(tx, resp, mode, div, sel, loop, lsb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
